// File: rtl/cla_seq_addsub.sv
// cla_seq_addsub: multi-cycle carry-lookahead adder/subtractor, one G-bit group per clock
module cla_seq_addsub #(
  parameter int W = 16,
  parameter int G = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [W-1:0] op_a,
  input  logic [W-1:0] op_b,
  input  logic         sub,
  input  logic         cin,
  output logic         busy,
  output logic         done,
  output logic [W-1:0] sum,
  output logic         cout,
  output logic         ovf,
  output logic         zero,
  output logic         pg,
  output logic         gg
);
  localparam int NG = W / G;
  localparam int KW = NG > 1 ? $clog2(NG) : 1;
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t state;
  logic [W-1:0] a_r, b_r, sum_n;
  logic [KW-1:0] k;
  logic c, gg_acc, pg_acc, last, pgrp, gg_n;
  logic [G-1:0] p, g;
  logic [G:0] cc, gc;
  // every carry is a flat sum of products of the group's g/p terms and the carry-in
  function automatic logic [G:0] lookahead(input logic [G-1:0] pv, input logic [G-1:0] gv, input logic ci);
    logic [G:0] r;
    logic t;
    r = '0;
    r[0] = ci;
    for (int j = 0; j < G; j++) begin
      t = ci;
      for (int m = 0; m <= j; m++) t &= pv[m];
      r[j+1] = t;
      for (int i = 0; i <= j; i++) begin
        t = gv[i];
        for (int m = i + 1; m <= j; m++) t &= pv[m];
        r[j+1] |= t;
      end
    end
    return r;
  endfunction
  always_comb begin
    p = a_r[G*k +: G] ^ b_r[G*k +: G];
    g = a_r[G*k +: G] & b_r[G*k +: G];
    cc = lookahead(p, g, c);
    gc = lookahead(p, g, 1'b0);
    pgrp = &p;
    gg_n = gc[G] | (pgrp & gg_acc);
    sum_n = sum;
    sum_n[G*k +: G] = p ^ cc[G-1:0];
    last = k == KW'(NG - 1);
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
      busy <= 1'b0;
      done <= 1'b0;
      sum <= '0;
      cout <= 1'b0;
      ovf <= 1'b0;
      zero <= 1'b0;
      pg <= 1'b0;
      gg <= 1'b0;
      k <= '0;
      c <= 1'b0;
      gg_acc <= 1'b0;
      pg_acc <= 1'b0;
      a_r <= '0;
      b_r <= '0;
    end else begin
      done <= 1'b0;
      if (state == RUN) begin
        sum <= sum_n;
        c <= cc[G];
        gg_acc <= gg_n;
        pg_acc <= pg_acc & pgrp;
        k <= k + 1'b1;
        if (last) begin
          state <= DONE;
          busy <= 1'b0;
          done <= 1'b1;
          cout <= cc[G];
          ovf <= cc[G] ^ cc[G-1];
          zero <= sum_n == '0;
          pg <= pg_acc & pgrp;
          gg <= gg_n;
        end
      end else if (start) begin
        state <= RUN;
        busy <= 1'b1;
        a_r <= op_a;
        b_r <= op_b ^ {W{sub}};
        c <= sub | cin;
        k <= '0;
        gg_acc <= 1'b0;
        pg_acc <= 1'b1;
      end else begin
        state <= IDLE;
      end
    end
  end
endmodule
